// File: rtl/neander_x_operand_fetch_if.sv
// Bus bundle for the NEANDER-X operand-fetch sequencer: command inputs,
// the req/ack memory read port and the operand valid/ready handoff.
//
// Handshakes:
//   memory : mem_req is held with a stable mem_addr until a cycle where
//            mem_ack=1. mem_rdata is taken in that same cycle. mem_ack
//            outside mem_req is meaningless and is ignored.
//   operand: op_valid is held with a stable op_data until a cycle where
//            op_valid=1 and op_ready=1. That edge transfers the byte.
//            op_ready may be high before op_valid rises.
interface neander_x_operand_fetch_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [1:0]        mode;
    logic [7:0]        arg;
    logic [7:0]        x_idx;
    logic              abort;
    logic              busy;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic              op_valid;
    logic [7:0]        op_data;
    logic              op_ready;
    logic [1:0]        fsm_state;

    // The sequencer itself
    modport slave (
        input  start, mode, arg, x_idx, abort, mem_ack, mem_rdata, op_ready,
        output busy, mem_req, mem_addr, op_valid, op_data, fsm_state
    );

    // Decode stage, memory and execute stage seen as one surrounding block
    modport master (
        output start, mode, arg, x_idx, abort, mem_ack, mem_rdata, op_ready,
        input  busy, mem_req, mem_addr, op_valid, op_data, fsm_state
    );
endinterface

// File: rtl/neander_x_operand_fetch.sv
// Operand-fetch sequencer feeding the ALU b input. It resolves immediate,
// direct, indirect and indexed operands through a req/ack memory port.
// It then offers the resulting byte on a valid/ready handoff.
// All outputs are registered. fsm_state mirrors the current state for debug.
module neander_x_operand_fetch #(
    parameter int ADDR_W = 8
) (
    input logic                     clk,
    input logic                     rst,
    neander_x_operand_fetch_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD1  = 2'd1,
        RD2  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [1:0] MODE_IMM = 2'b00;
    localparam logic [1:0] MODE_IND = 2'b10;
    localparam logic [1:0] MODE_IDX = 2'b11;

    state_t            state;
    logic [1:0]        mode_q;
    logic              busy_q;
    logic              mem_req_q;
    logic              op_valid_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        op_data_q;
    logic [7:0]        idx_sum;

    // Indexed address is an 8-bit sum, so the carry is dropped and it wraps
    assign idx_sum = bus.arg + bus.x_idx;

    function automatic logic [ADDR_W-1:0] to_addr(input logic [7:0] b);
        return ADDR_W'(b);
    endfunction

    // Sequencer: abort wins over everything; accept only in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mode_q     <= MODE_IMM;
            busy_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            op_valid_q <= 1'b0;
            mem_addr_q <= '0;
            op_data_q  <= 8'h00;
        end else if (bus.abort) begin
            state      <= IDLE;
            busy_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            op_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mode_q <= bus.mode;
                        busy_q <= 1'b1;
                        case (bus.mode)
                            MODE_IMM: begin
                                op_data_q  <= bus.arg;
                                op_valid_q <= 1'b1;
                                state      <= HOLD;
                            end
                            MODE_IDX: begin
                                mem_addr_q <= to_addr(idx_sum);
                                mem_req_q  <= 1'b1;
                                state      <= RD1;
                            end
                            default: begin
                                // DIR and IND both read at arg first
                                mem_addr_q <= to_addr(bus.arg);
                                mem_req_q  <= 1'b1;
                                state      <= RD1;
                            end
                        endcase
                    end
                end
                RD1: begin
                    if (bus.mem_ack) begin
                        if (mode_q == MODE_IND) begin
                            // Pointer fetched; keep mem_req high into RD2
                            mem_addr_q <= to_addr(bus.mem_rdata);
                            state      <= RD2;
                        end else begin
                            op_data_q  <= bus.mem_rdata;
                            mem_req_q  <= 1'b0;
                            op_valid_q <= 1'b1;
                            state      <= HOLD;
                        end
                    end
                end
                RD2: begin
                    if (bus.mem_ack) begin
                        op_data_q  <= bus.mem_rdata;
                        mem_req_q  <= 1'b0;
                        op_valid_q <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.op_ready) begin
                        op_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.op_valid  = op_valid_q;
    assign bus.op_data   = op_data_q;
    assign bus.fsm_state = state;

endmodule

// File: doc/neander_x_operand_fetch.md
# neander_x_operand_fetch

Operand-fetch sequencer for the NEANDER-X datapath. It sits directly upstream of the ALU and resolves the ALU's second operand (`b`) for a data-processing instruction. It handles four addressing modes: immediate, direct, indirect and indexed. Memory reads go through a simple req/ack port. The resolved byte is presented on a valid/ready handshake to the execute stage, which drives it onto the ALU `b` input.

## Interface
Parameters:
- `ADDR_W`, default 8: memory address width. The operand/data width is fixed at 8.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a fetch. Sampled only when `busy`=0.
- `mode`  in  2  addressing mode: 00 IMM, 01 DIR, 10 IND, 11 IDX.
- `arg`  in  8  instruction operand byte: immediate value, address, or pointer address.
- `x_idx`  in  8  index register value. Used by IDX only.
- `abort`  in  1  synchronous cancel, e.g. from pipeline flush.
- `busy`  out  1  high from the cycle after `start` is accepted until the return to IDLE.
- `mem_req`  out  1  memory read request.
- `mem_addr`  out  ADDR_W  read address. Stable while `mem_req`=1.
- `mem_ack`  in  1  read complete. `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  8  read data.
- `op_valid`  out  1  resolved operand available.
- `op_data`  out  8  resolved operand, destined for ALU `b`.
- `op_ready`  in  1  downstream accepts the operand.

## Operation
- The FSM has four states: IDLE, RD1, RD2, HOLD.
- `start`=1 in IDLE latches `mode`, `arg` and `x_idx`. Later changes to these inputs are ignored until the next accept.
- IDLE transitions on accept:
  - IMM: `op_data`←`arg`, go to HOLD.
  - DIR: `mem_addr`←`arg`, go to RD1.
  - IDX: `mem_addr`←(`arg`+`x_idx`) mod 256, go to RD1. Carry is discarded, so the address wraps.
  - IND: `mem_addr`←`arg`, go to RD1.
- RD1, `mem_req`=1:
  - Waits indefinitely until `mem_ack`.
  - On ack with mode IND: `mem_addr`←`mem_rdata`, go to RD2.
  - On ack with any other mode: `op_data`←`mem_rdata`, go to HOLD.
- RD2, `mem_req`=1: on ack, `op_data`←`mem_rdata`, go to HOLD.
- HOLD, `op_valid`=1: `op_data` is held stable. When `op_valid` and `op_ready` are both high, go to IDLE.
- `mem_ack` is ignored whenever `mem_req`=0.
- `abort`=1 in any state causes:
  - next state IDLE;
  - `mem_req`, `op_valid` and `busy` all 0 next cycle;
  - a simultaneous `mem_ack` or `op_ready` is ignored, with no capture and no handoff;
  - `abort` takes priority over `start`.
- `start` is ignored while `busy`=1, including in HOLD. A back-to-back fetch therefore needs one IDLE cycle.

## Timing
- All outputs are registered.
- Reset values: state IDLE; `busy`, `mem_req`, `op_valid` = 0; `mem_addr`, `op_data` = 0.
- Reset mid-transaction drops `mem_req` immediately (asynchronous). Any later `mem_ack` is ignored.
- `start` is accepted at edge 0. `busy` rises after edge 0.
- Latency from `start` to `op_valid`, with ack returned in the first request cycle:
  - IMM: 1 cycle.
  - DIR/IDX: 2 cycles. `mem_req` is high for cycle 1 only.
  - IND: 3 cycles.
- Each wait cycle on `mem_ack` adds 1 cycle.
- `mem_req` does not drop between RD1 and RD2 for IND. `mem_addr` changes at the RD1→RD2 edge.
- Handshake completes at edge N, when `op_valid`·`op_ready`=1. After edge N, `op_valid`=0 and `busy`=0.
- If `op_ready` is already high when HOLD is entered, HOLD lasts exactly one cycle.

## Test plan
- Reset, then IMM with `arg`=0x5A, `op_ready`=1 → `op_valid` 1 cycle after start, `op_data`=0x5A, `mem_req` never asserted, `busy` low 2 cycles after start.
- DIR `arg`=0x20, memory model mem[0x20]=0x33 with 3 wait cycles → `mem_addr`=0x20 stable for 4 `mem_req` cycles, `op_data`=0x33, `op_valid` at cycle 5.
- IND `arg`=0x10, mem[0x10]=0x80, mem[0x80]=0xC4, zero wait → `mem_addr` 0x10 then 0x80 on consecutive cycles, `mem_req` continuous, `op_data`=0xC4 at cycle 3.
- IDX `arg`=0xFF, `x_idx`=0x02, mem[0x01]=0x77 → `mem_addr`=0x01 (wrap), `op_data`=0x77.
- HOLD with `op_ready`=0 for 4 cycles while `arg`/`mode` toggle and `start` pulses → `op_data` stable, no new fetch. Raise `op_ready` → `op_valid` drops next cycle.
- `abort` asserted together with `mem_ack` in RD1 of an IND fetch → no capture, IDLE next cycle, outputs 0. Likewise async `rst` during RD2 → `mem_req` low immediately.
